// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory request port between the
// instruction fetch channel (I) and the data channel (D).
//
// Arbitration is combinational in IDLE, so a request is forwarded with no
// added latency. Ownership then locks to the winner until its transfer acks.
// Conflicts resolve by fixed data priority (DATA_PRIO=1) or round-robin
// (DATA_PRIO=0). A starvation guard forces I to win after MAX_WAIT
// consecutive lost cycles.
//
// Optional feature: define ARB_PERF_CNT_EN to build saturating performance
// counters. Without it, the perf_* ports are tied to zero and no counter
// flops exist.
module mem_port_arbiter #(
  parameter bit          DATA_PRIO   = 1'b1,
  parameter int unsigned MAX_WAIT    = 4,
  parameter logic [2:0]  IFETCH_SIZE = 3'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction channel
  input  logic        i_req_val,
  input  logic [31:0] i_req_addr,
  output logic        i_req_ack,
  output logic [31:0] i_ack_rdata,
  // data channel
  input  logic        d_req_val,
  input  logic [31:0] d_req_addr,
  input  logic [2:0]  d_req_cop,
  input  logic [31:0] d_req_wdata,
  input  logic [2:0]  d_req_size,
  output logic        d_req_ack,
  output logic [31:0] d_ack_rdata,
  // downstream port
  output logic        m_req_val,
  output logic [31:0] m_req_addr,
  output logic [2:0]  m_req_cop,
  output logic [31:0] m_req_wdata,
  output logic [2:0]  m_req_size,
  output logic        m_req_src,
  input  logic        m_req_ack,
  input  logic [31:0] m_ack_rdata,
  // performance counters
  output logic [31:0] perf_i_cnt,
  output logic [31:0] perf_d_cnt,
  output logic [31:0] perf_conf_cnt
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_I = 2'd1,
    ST_OWN_D = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_last_d;      // 1 = the last acked transfer belonged to D
  logic [3:0]  r_wait_cnt;    // consecutive cycles I lost while requesting
  logic        w_sel_i;
  logic        w_sel_d;
  logic        w_fwd_i;
  logic        w_fwd_d;

  // Select the channel forwarded this cycle and decide the next state.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_sel_i      = 1'b0;
    w_sel_d      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req_val && d_req_val) begin
          if (r_wait_cnt >= WAIT_MAX) w_sel_i = 1'b1;
          else if (DATA_PRIO)         w_sel_d = 1'b1;
          else if (r_last_d)          w_sel_i = 1'b1;
          else                        w_sel_d = 1'b1;
        end else begin
          w_sel_i = i_req_val;
          w_sel_d = d_req_val;
        end
        if (w_sel_i && !m_req_ack)      w_next_state = ST_OWN_I;
        else if (w_sel_d && !m_req_ack) w_next_state = ST_OWN_D;
      end
      ST_OWN_I: begin
        // An owner dropping val before its ack releases the port.
        w_sel_i = i_req_val;
        if (m_req_ack || !i_req_val) w_next_state = ST_IDLE;
      end
      ST_OWN_D: begin
        w_sel_d = d_req_val;
        if (m_req_ack || !d_req_val) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // While reset is held nothing is forwarded, even if requests stay asserted.
  assign w_fwd_i = w_sel_i & rst_n;
  assign w_fwd_d = w_sel_d & rst_n;

  // Downstream request mux. I fetches are word reads with no write data.
  assign m_req_val   = w_fwd_i | w_fwd_d;
  assign m_req_src   = w_fwd_d;
  assign m_req_addr  = w_fwd_d ? d_req_addr  : (w_fwd_i ? i_req_addr : 32'd0);
  assign m_req_cop   = w_fwd_d ? d_req_cop   : 3'b000;
  assign m_req_wdata = w_fwd_d ? d_req_wdata : 32'd0;
  assign m_req_size  = w_fwd_d ? d_req_size  : (w_fwd_i ? IFETCH_SIZE : 3'd0);

  // Acks go only to the forwarded channel. Read data is broadcast while a
  // request is forwarded, so outputs stay quiet when nothing is pending.
  assign i_req_ack   = m_req_ack & w_fwd_i;
  assign d_req_ack   = m_req_ack & w_fwd_d;
  assign i_ack_rdata = m_req_val ? m_ack_rdata : 32'd0;
  assign d_ack_rdata = m_req_val ? m_ack_rdata : 32'd0;

  // State register, round-robin history and I starvation counter.
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_last_d   <= 1'b0;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state <= w_next_state;
      if (m_req_ack && m_req_val) r_last_d <= w_fwd_d;
      if (m_req_ack && w_fwd_i)
        r_wait_cnt <= 4'd0;
      else if (i_req_val && !w_fwd_i && (r_wait_cnt < WAIT_MAX))
        r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perf_i;
  logic [31:0] r_perf_d;
  logic [31:0] r_perf_conf;

  // Saturating counters: acked I/D transfers and cycles with both requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_i    <= 32'd0;
      r_perf_d    <= 32'd0;
      r_perf_conf <= 32'd0;
    end else begin
      if (i_req_ack && (r_perf_i != 32'hFFFF_FFFF))
        r_perf_i <= r_perf_i + 32'd1;
      if (d_req_ack && (r_perf_d != 32'hFFFF_FFFF))
        r_perf_d <= r_perf_d + 32'd1;
      if (i_req_val && d_req_val && (r_perf_conf != 32'hFFFF_FFFF))
        r_perf_conf <= r_perf_conf + 32'd1;
    end
  end

  assign perf_i_cnt    = r_perf_i;
  assign perf_d_cnt    = r_perf_d;
  assign perf_conf_cnt = r_perf_conf;
`else
  assign perf_i_cnt    = 32'd0;
  assign perf_d_cnt    = 32'd0;
  assign perf_conf_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter.
// The driver applies one cycle of stimulus after each rising edge. It asks
// the reference model what the port must show and queues that expectation.
// The monitor pops and compares on the falling edge. A second instance with
// round-robin arbitration shares the inputs and is checked in one phase.
module tb_mem_port_arbiter;

  localparam int MAX_WAIT = 4;
`ifdef ARB_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_val, d_req_val, m_req_ack;
  logic [31:0] i_req_addr, d_req_addr, d_req_wdata, m_ack_rdata;
  logic [2:0]  d_req_cop, d_req_size;

  logic        i_req_ack, d_req_ack, m_req_val, m_req_src;
  logic [31:0] i_ack_rdata, d_ack_rdata, m_req_addr, m_req_wdata;
  logic [2:0]  m_req_cop, m_req_size;
  logic [31:0] perf_i_cnt, perf_d_cnt, perf_conf_cnt;

  logic        rr_i_ack, rr_d_ack, rr_m_val, rr_m_src;
  logic [31:0] rr_i_rdata, rr_d_rdata, rr_m_addr, rr_m_wdata;
  logic [2:0]  rr_m_cop, rr_m_size;
  logic [31:0] rr_perf_i, rr_perf_d, rr_perf_c;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_PRIO(1'b1), .MAX_WAIT(MAX_WAIT), .IFETCH_SIZE(3'd2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_val(i_req_val), .i_req_addr(i_req_addr),
    .i_req_ack(i_req_ack), .i_ack_rdata(i_ack_rdata),
    .d_req_val(d_req_val), .d_req_addr(d_req_addr), .d_req_cop(d_req_cop),
    .d_req_wdata(d_req_wdata), .d_req_size(d_req_size),
    .d_req_ack(d_req_ack), .d_ack_rdata(d_ack_rdata),
    .m_req_val(m_req_val), .m_req_addr(m_req_addr), .m_req_cop(m_req_cop),
    .m_req_wdata(m_req_wdata), .m_req_size(m_req_size), .m_req_src(m_req_src),
    .m_req_ack(m_req_ack), .m_ack_rdata(m_ack_rdata),
    .perf_i_cnt(perf_i_cnt), .perf_d_cnt(perf_d_cnt), .perf_conf_cnt(perf_conf_cnt)
  );

  mem_port_arbiter #(.DATA_PRIO(1'b0), .MAX_WAIT(MAX_WAIT), .IFETCH_SIZE(3'd2)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .i_req_val(i_req_val), .i_req_addr(i_req_addr),
    .i_req_ack(rr_i_ack), .i_ack_rdata(rr_i_rdata),
    .d_req_val(d_req_val), .d_req_addr(d_req_addr), .d_req_cop(d_req_cop),
    .d_req_wdata(d_req_wdata), .d_req_size(d_req_size),
    .d_req_ack(rr_d_ack), .d_ack_rdata(rr_d_rdata),
    .m_req_val(rr_m_val), .m_req_addr(rr_m_addr), .m_req_cop(rr_m_cop),
    .m_req_wdata(rr_m_wdata), .m_req_size(rr_m_size), .m_req_src(rr_m_src),
    .m_req_ack(m_req_ack), .m_ack_rdata(m_ack_rdata),
    .perf_i_cnt(rr_perf_i), .perf_d_cnt(rr_perf_d), .perf_conf_cnt(rr_perf_c)
  );

  typedef struct {
    logic        m_val;
    logic        m_src;
    logic [31:0] m_addr;
    logic [2:0]  m_cop;
    logic [31:0] m_wdata;
    logic [2:0]  m_size;
    logic        i_ack;
    logic        d_ack;
    logic [31:0] rdata;
    logic [31:0] p_i;
    logic [31:0] p_d;
    logic [31:0] p_c;
    bit          chk_rr;
    logic        rr_src;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: who holds the port (none/I/D), who was granted last,
  // how long I has been starved, and transfer/conflict tallies.
  typedef enum int { OWN_NONE, OWN_I, OWN_D } owner_t;
  owner_t m_owner   = OWN_NONE;
  bit     m_last_d  = 1'b0;
  int     m_starve  = 0;
  int     m_cnt_i   = 0;
  int     m_cnt_d   = 0;
  int     m_cnt_c   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; returns whether each channel was acked.
  task automatic drive_cycle(
    input bit rst, input bit iv, input logic [31:0] ia,
    input bit dv, input logic [31:0] da, input logic [2:0] dc,
    input logic [31:0] dw, input logic [2:0] ds, input bit mack,
    input bit chk_rr, input bit rr_src,
    output bit i_done, output bit d_done);
    owner_t win;
    exp_t   e;
    @(posedge clk);
    #1;
    rst_n       = !rst;
    i_req_val   = iv;  i_req_addr  = ia;
    d_req_val   = dv;  d_req_addr  = da;
    d_req_cop   = dc;  d_req_wdata = dw;  d_req_size = ds;
    m_req_ack   = mack;
    m_ack_rdata = $urandom;

    // Who holds the port this cycle.
    if (rst)                       win = OWN_NONE;
    else if (m_owner == OWN_I)     win = iv ? OWN_I : OWN_NONE;
    else if (m_owner == OWN_D)     win = dv ? OWN_D : OWN_NONE;
    else if (iv && dv)
      win = (m_starve >= MAX_WAIT) ? OWN_I : OWN_D;   // data priority instance
    else if (iv)                   win = OWN_I;
    else if (dv)                   win = OWN_D;
    else                           win = OWN_NONE;

    e.m_val   = (win != OWN_NONE);
    e.m_src   = (win == OWN_D);
    e.m_addr  = (win == OWN_D) ? da : (win == OWN_I) ? ia : 32'd0;
    e.m_cop   = (win == OWN_D) ? dc : 3'd0;
    e.m_wdata = (win == OWN_D) ? dw : 32'd0;
    e.m_size  = (win == OWN_D) ? ds : (win == OWN_I) ? 3'd2 : 3'd0;
    e.i_ack   = mack && (win == OWN_I);
    e.d_ack   = mack && (win == OWN_D);
    e.rdata   = e.m_val ? m_ack_rdata : 32'd0;
    e.p_i     = (PERF_EN && !rst) ? 32'(m_cnt_i) : 32'd0;
    e.p_d     = (PERF_EN && !rst) ? 32'(m_cnt_d) : 32'd0;
    e.p_c     = (PERF_EN && !rst) ? 32'(m_cnt_c) : 32'd0;
    e.chk_rr  = chk_rr;
    e.rr_src  = rr_src;
    sb_q.push_back(e);

    i_done = e.i_ack;
    d_done = e.d_ack;
    if (rst) begin
      m_owner = OWN_NONE; m_last_d = 1'b0; m_starve = 0;
      m_cnt_i = 0; m_cnt_d = 0; m_cnt_c = 0;
    end else begin
      if (iv && dv) m_cnt_c++;
      if (win == OWN_I && mack) begin
        m_starve = 0;
      end else if (iv && win != OWN_I) begin
        m_starve = (m_starve < MAX_WAIT) ? m_starve + 1 : MAX_WAIT;
      end
      if (win != OWN_NONE && mack) begin
        m_last_d = (win == OWN_D);
        if (win == OWN_I) m_cnt_i++; else m_cnt_d++;
        m_owner = OWN_NONE;
      end else begin
        m_owner = win;
      end
    end
  endtask

  // Monitor: compare whatever the port presents against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("m_req_val",   32'(m_req_val),   32'(e.m_val));
      check("m_req_src",   32'(m_req_src),   32'(e.m_src));
      check("m_req_addr",  m_req_addr,       e.m_addr);
      check("m_req_cop",   32'(m_req_cop),   32'(e.m_cop));
      check("m_req_wdata", m_req_wdata,      e.m_wdata);
      check("m_req_size",  32'(m_req_size),  32'(e.m_size));
      check("i_req_ack",   32'(i_req_ack),   32'(e.i_ack));
      check("d_req_ack",   32'(d_req_ack),   32'(e.d_ack));
      if (e.i_ack) check("i_ack_rdata", i_ack_rdata, e.rdata);
      if (e.d_ack) check("d_ack_rdata", d_ack_rdata, e.rdata);
      check("perf_i_cnt",    perf_i_cnt,    e.p_i);
      check("perf_d_cnt",    perf_d_cnt,    e.p_d);
      check("perf_conf_cnt", perf_conf_cnt, e.p_c);
      if (e.chk_rr) begin
        check("rr_m_req_val", 32'(rr_m_val), 32'd1);
        check("rr_m_req_src", 32'(rr_m_src), 32'(e.rr_src));
      end
    end
  end

  initial begin
    bit id, dd;
    bit ip, dp;
    logic [31:0] ia, da, dw;
    logic [2:0]  dc, ds;

    rst_n = 1'b0;
    i_req_val = 1'b0; i_req_addr = 32'd0;
    d_req_val = 1'b0; d_req_addr = 32'd0; d_req_cop = 3'd0;
    d_req_wdata = 32'd0; d_req_size = 3'd0;
    m_req_ack = 1'b0; m_ack_rdata = 32'd0;

    // Reset: all outputs idle, even with a stray downstream ack.
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, id, dd);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, id, dd);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, id, dd);

    // Both requesting with single-cycle acks. With data priority, D wins four
    // times and then the starved I wins. Round-robin alternates, starting with D.
    for (int k = 0; k < 8; k++)
      drive_cycle(0, 1, 32'h200, 1, 32'h300, 3'b001, 32'hA5A5_0000 + k, 3'd2,
                  1, 1, (k % 2) == 0, id, dd);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, id, dd);

    // D alone, acked in the same cycle.
    drive_cycle(0, 0, 0, 1, 32'h100, 3'b001, 32'hDEAD_BEEF, 3'd2, 1, 0, 0, id, dd);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, id, dd);

    // I alone, acked after three cycles.
    drive_cycle(0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, id, dd);
    drive_cycle(0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, id, dd);
    drive_cycle(0, 1, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0, id, dd);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, id, dd);

    // D owns the port; I arrives and waits until after D's ack.
    drive_cycle(0, 0, 0,      1, 32'h500, 3'b000, 0, 3'd1, 0, 0, 0, id, dd);
    drive_cycle(0, 1, 32'h80, 1, 32'h500, 3'b000, 0, 3'd1, 0, 0, 0, id, dd);
    drive_cycle(0, 1, 32'h80, 1, 32'h500, 3'b000, 0, 3'd1, 1, 0, 0, id, dd);
    drive_cycle(0, 1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0, id, dd);
    drive_cycle(0, 1, 32'h80, 0, 0, 0, 0, 0, 1, 0, 0, id, dd);

    // Reset in the middle of a D transfer drops ownership at once.
    drive_cycle(0, 0, 0, 1, 32'h600, 3'b011, 32'h1234, 3'd0, 0, 0, 0, id, dd);
    drive_cycle(1, 0, 0, 1, 32'h600, 3'b011, 32'h1234, 3'd0, 0, 0, 0, id, dd);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, id, dd);

    // Random traffic: masters hold requests until acked and occasionally drop
    // one early. The downstream acks at random.
    ip = 1'b0; dp = 1'b0; ia = 0; da = 0; dw = 0; dc = 0; ds = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!ip && $urandom_range(0, 99) < 55) begin
        ip = 1'b1; ia = $urandom & 32'hFFFF_FFFC;
      end
      if (!dp && $urandom_range(0, 99) < 55) begin
        dp = 1'b1; da = $urandom; dw = $urandom;
        dc = 3'($urandom_range(0, 7)); ds = 3'($urandom_range(0, 7));
      end
      if (ip && $urandom_range(0, 99) < 2) ip = 1'b0;
      if (dp && $urandom_range(0, 99) < 2) dp = 1'b0;
      drive_cycle(0, ip, ia, dp, da, dc, dw, ds, $urandom_range(0, 99) < 40,
                  0, 0, id, dd);
      if (id) ip = 1'b0;
      if (dd) dp = 1'b0;
    end
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, id, dd);

    // Let the monitor drain the scoreboard, within a bounded number of cycles.
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
